// File: rtl/rf_arb_pkg.sv
// Shared constants for the two-port register-file arbiter.
// RW op codes ({RD,WR}) and the arbiter FSM state encoding.
package rf_arb_pkg;

  localparam logic [1:0] RW_NOP  = 2'b00;
  localparam logic [1:0] RW_WR   = 2'b01;
  localparam logic [1:0] RW_RD   = 2'b10;
  localparam logic [1:0] RW_RDWR = 2'b11;

  typedef enum logic {
    CLEAR = 1'b0,
    RUN   = 1'b1
  } state_t;

endpackage

// File: rtl/rr_arb2.sv
// Two-requester round-robin arbiter, combinational one-hot grant.
// Ports: clk, rst (sync, active-low), en, req[1:0] -> gnt[1:0].
module rr_arb2 (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic [1:0] req,
  output logic [1:0] gnt
);

  // index of the most recently granted requester
  logic last;

  always_comb begin
    gnt = 2'b00;
    if (en) begin
      if (&req) gnt = last ? 2'b01 : 2'b10;
      else      gnt = req;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst)      last <= 1'b1;
    else if (|gnt) last <= gnt[1];
  end

endmodule

// File: rtl/rf_port_arbiter.sv
// Arbitrates two requesters onto one register-file port, clears
// the file after reset and returns registered read responses.
// Ports: clk, rst (sync, active-low), req/rw_in/da_in/aa_in/ba_in/
// d_in from requesters, gnt, rf_* drive, rf_a/rf_b read data,
// rsp_valid/rsp_id/rsp_a/rsp_b response, ready.
// Option: RF_ARB_BYPASS_EN forwards write data on read+write hits.
module rf_port_arbiter
  import rf_arb_pkg::*;
#(
  parameter int DW = 16,
  parameter int AW = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [1:0]      req,
  input  logic [3:0]      rw_in,
  input  logic [2*AW-1:0] da_in,
  input  logic [2*AW-1:0] aa_in,
  input  logic [2*AW-1:0] ba_in,
  input  logic [2*DW-1:0] d_in,
  output logic [1:0]      gnt,
  output logic [DW-1:0]   rf_d,
  output logic [AW-1:0]   rf_da,
  output logic [AW-1:0]   rf_aa,
  output logic [AW-1:0]   rf_ba,
  output logic [1:0]      rf_rw,
  output logic            rf_en,
  output logic            rf_rst,
  input  logic [DW-1:0]   rf_a,
  input  logic [DW-1:0]   rf_b,
  output logic            rsp_valid,
  output logic            rsp_id,
  output logic [DW-1:0]   rsp_a,
  output logic [DW-1:0]   rsp_b,
  output logic            ready
);

  state_t state;
  logic run, clr, sel, any, rd_go;
  logic [1:0]    rw_g;
  logic [DW-1:0] d_g;
  logic [AW-1:0] da_g, aa_g, ba_g;
  logic          v_q, id_q;
  logic [DW-1:0] a_q, b_q;

  // rst gates everything so nothing reaches the file while low
  assign run = rst & (state == RUN);
  assign clr = rst & (state == CLEAR);

  rr_arb2 u_arb (
    .clk (clk),
    .rst (rst),
    .en  (run),
    .req (req),
    .gnt (gnt)
  );

  assign sel  = gnt[1];
  assign any  = |gnt;
  assign rw_g = sel ? rw_in[3:2] : rw_in[1:0];
  assign d_g  = sel ? d_in[2*DW-1:DW] : d_in[DW-1:0];
  assign da_g = sel ? da_in[2*AW-1:AW] : da_in[AW-1:0];
  assign aa_g = sel ? aa_in[2*AW-1:AW] : aa_in[AW-1:0];
  assign ba_g = sel ? ba_in[2*AW-1:AW] : ba_in[AW-1:0];

  assign rd_go = any & ((rw_g == RW_RD) | (rw_g == RW_RDWR));

  assign rf_en  = clr | any;
  assign rf_rst = clr;
  assign rf_rw  = any ? rw_g : RW_NOP;
  assign rf_d   = d_g;
  assign rf_da  = da_g;
  assign rf_aa  = aa_g;
  assign rf_ba  = ba_g;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= CLEAR;
      ready <= 1'b0;
    end else begin
      unique case (state)
        CLEAR: begin
          state <= RUN;
          ready <= 1'b1;
        end
        RUN: state <= RUN;
        default: state <= CLEAR;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      v_q  <= 1'b0;
      id_q <= 1'b0;
      a_q  <= '0;
      b_q  <= '0;
    end else begin
      v_q <= rd_go;
      if (rd_go) begin
        id_q <= sel;
        a_q  <= rf_a;
        b_q  <= rf_b;
      end
    end
  end

  // a reset arriving in the response cycle suppresses it
  assign rsp_valid = v_q & rst;
  assign rsp_id    = id_q;

`ifdef RF_ARB_BYPASS_EN
  logic [DW-1:0] d_q;
  logic [AW-1:0] da_q;
  logic          ma_q, mb_q;

  always_ff @(posedge clk) begin
    if (!rst) begin
      d_q  <= '0;
      da_q <= '0;
      ma_q <= 1'b0;
      mb_q <= 1'b0;
    end else if (rd_go) begin
      d_q  <= d_g;
      da_q <= da_g;
      ma_q <= (rw_g == RW_RDWR) & (aa_g == da_g);
      mb_q <= (rw_g == RW_RDWR) & (ba_g == da_g);
    end
  end

  assign rsp_a = ma_q ? d_q : a_q;
  assign rsp_b = mb_q ? d_q : b_q;
`else
  assign rsp_a = a_q;
  assign rsp_b = b_q;
`endif

endmodule

// File: tb/tb_rf_port_arbiter.sv
// Directed bench for rf_port_arbiter with a behavioural register
// file and a queue of expected read responses.
module tb_rf_port_arbiter;

  localparam int DW = 16;
  localparam int AW = 4;

  localparam logic [1:0] NOP  = 2'b00;
  localparam logic [1:0] WR   = 2'b01;
  localparam logic [1:0] RD   = 2'b10;
  localparam logic [1:0] RDWR = 2'b11;

`ifdef RF_ARB_BYPASS_EN
  localparam logic [15:0] HIT = 16'h2222;
`else
  localparam logic [15:0] HIT = 16'h1111;
`endif

  logic            clk = 1'b0;
  logic            rst;
  logic [1:0]      req;
  logic [3:0]      rw_in;
  logic [2*AW-1:0] da_in, aa_in, ba_in;
  logic [2*DW-1:0] d_in;
  logic [1:0]      gnt;
  logic [DW-1:0]   rf_d;
  logic [AW-1:0]   rf_da, rf_aa, rf_ba;
  logic [1:0]      rf_rw;
  logic            rf_en, rf_rst;
  logic [DW-1:0]   rf_a, rf_b;
  logic            rsp_valid, rsp_id;
  logic [DW-1:0]   rsp_a, rsp_b;
  logic            ready;

  rf_port_arbiter #(.DW(DW), .AW(AW)) dut (
    .clk       (clk),
    .rst       (rst),
    .req       (req),
    .rw_in     (rw_in),
    .da_in     (da_in),
    .aa_in     (aa_in),
    .ba_in     (ba_in),
    .d_in      (d_in),
    .gnt       (gnt),
    .rf_d      (rf_d),
    .rf_da     (rf_da),
    .rf_aa     (rf_aa),
    .rf_ba     (rf_ba),
    .rf_rw     (rf_rw),
    .rf_en     (rf_en),
    .rf_rst    (rf_rst),
    .rf_a      (rf_a),
    .rf_b      (rf_b),
    .rsp_valid (rsp_valid),
    .rsp_id    (rsp_id),
    .rsp_a     (rsp_a),
    .rsp_b     (rsp_b),
    .ready     (ready)
  );

  always #5 clk = ~clk;

  // register file: combinational read, write/clear on the edge
  logic [DW-1:0] regs [16];
  assign rf_a = regs[rf_aa];
  assign rf_b = regs[rf_ba];

  always_ff @(posedge clk) begin
    if (rf_en) begin
      if (rf_rst) begin
        for (int k = 0; k < 16; k++) regs[k] <= '0;
      end else if (rf_rw[0]) begin
        regs[rf_da] <= rf_d;
      end
    end
  end

  typedef struct {
    logic        id;
    logic [15:0] a;
    logic [15:0] b;
  } rsp_t;

  rsp_t exp_q[$];
  int   nvec = 0;
  int   nerr = 0;
  bit   due  = 1'b0;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    nvec++;
    assert (got === exp) else begin
      nerr++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  task automatic idle();
    req   = 2'b00;
    rw_in = '0;
    da_in = '0;
    aa_in = '0;
    ba_in = '0;
    d_in  = '0;
  endtask

  task automatic op(input int i, input logic [1:0] rw,
                    input logic [3:0] da, input logic [3:0] aa,
                    input logic [3:0] ba, input logic [15:0] d);
    req[i]          = 1'b1;
    rw_in[2*i +: 2] = rw;
    da_in[AW*i +: AW] = da;
    aa_in[AW*i +: AW] = aa;
    ba_in[AW*i +: AW] = ba;
    d_in[DW*i +: DW]  = d;
  endtask

  task automatic push(input logic id, input logic [15:0] a,
                      input logic [15:0] b);
    rsp_t e;
    e.id = id;
    e.a  = a;
    e.b  = b;
    exp_q.push_back(e);
  endtask

  // sample at the falling edge: response from last cycle, then gnt
  task automatic tick(input logic [1:0] eg, input bit rd);
    rsp_t e;
    @(negedge clk);
    chk("rsp_valid", 32'(rsp_valid), 32'(due));
    if (due) begin
      if (exp_q.size() == 0) begin
        chk("scoreboard_empty", 32'd1, 32'd0);
      end else begin
        e = exp_q.pop_front();
        chk("rsp_id", 32'(rsp_id), 32'(e.id));
        chk("rsp_a", 32'(rsp_a), 32'(e.a));
        chk("rsp_b", 32'(rsp_b), 32'(e.b));
      end
    end
    chk("gnt", 32'(gnt), 32'(eg));
    due = rd;
  endtask

  task automatic adv();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b0;
    idle();
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    chk("rst_ready", 32'(ready), 32'd0);
    chk("rst_gnt", 32'(gnt), 32'd0);
    chk("rst_rf_en", 32'(rf_en), 32'd0);
    chk("rst_rf_rst", 32'(rf_rst), 32'd0);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_rsp_id", 32'(rsp_id), 32'd0);
    chk("rst_rsp_a", 32'(rsp_a), 32'd0);
    chk("rst_rsp_b", 32'(rsp_b), 32'd0);

    adv();
    rst = 1'b1;
    req = 2'b11;
    @(negedge clk);
    chk("clr_rf_en", 32'(rf_en), 32'd1);
    chk("clr_rf_rst", 32'(rf_rst), 32'd1);
    chk("clr_gnt", 32'(gnt), 32'd0);
    chk("clr_ready", 32'(ready), 32'd0);
    adv();
    idle();
    @(negedge clk);
    chk("run_ready", 32'(ready), 32'd1);
    chk("run_rf_rst", 32'(rf_rst), 32'd0);
    chk("run_rf_en", 32'(rf_en), 32'd0);
    chk("run_rf_rw", 32'(rf_rw), 32'd0);
    adv();

    // cleared register reads back zero
    op(0, RD, 4'd0, 4'd3, 4'd0, 16'h0);
    push(1'b0, 16'h0000, 16'h0000);
    tick(2'b01, 1'b1);
    adv();
    idle();
    tick(2'b00, 1'b0);
    adv();

    // write by 0, read by 1
    op(0, WR, 4'd5, 4'd0, 4'd0, 16'hBEEF);
    tick(2'b01, 1'b0);
    chk("wr_rf_en", 32'(rf_en), 32'd1);
    chk("wr_rf_rw", 32'(rf_rw), 32'(WR));
    chk("wr_rf_da", 32'(rf_da), 32'd5);
    chk("wr_rf_d", 32'(rf_d), 32'hBEEF);
    adv();
    idle();
    op(1, RD, 4'd0, 4'd5, 4'd5, 16'h0);
    push(1'b1, 16'hBEEF, 16'hBEEF);
    tick(2'b10, 1'b1);
    adv();
    idle();
    tick(2'b00, 1'b0);
    adv();

    // contention alternates, requester 0 first
    op(0, NOP, 4'd0, 4'd0, 4'd0, 16'h0);
    op(1, NOP, 4'd0, 4'd0, 4'd0, 16'h0);
    tick(2'b01, 1'b0);
    adv();
    tick(2'b10, 1'b0);
    adv();
    tick(2'b01, 1'b0);
    adv();
    tick(2'b10, 1'b0);
    adv();

    // lone requester granted back to back
    idle();
    op(1, NOP, 4'd0, 4'd0, 4'd0, 16'h0);
    tick(2'b10, 1'b0);
    adv();
    tick(2'b10, 1'b0);
    adv();

    // read+write hit on r7
    idle();
    op(0, WR, 4'd7, 4'd0, 4'd0, 16'h1111);
    tick(2'b01, 1'b0);
    adv();
    op(0, RDWR, 4'd7, 4'd7, 4'd7, 16'h2222);
    push(1'b0, HIT, HIT);
    tick(2'b01, 1'b1);
    adv();
    idle();
    tick(2'b00, 1'b0);
    adv();
    op(0, RD, 4'd0, 4'd7, 4'd0, 16'h0);
    push(1'b0, 16'h2222, 16'h0000);
    tick(2'b01, 1'b1);
    adv();
    idle();
    tick(2'b00, 1'b0);
    adv();

    // last grant was 0, so 1 wins; 0 withdraws unserved
    op(0, WR, 4'd9, 4'd0, 4'd0, 16'hAAAA);
    op(1, WR, 4'd10, 4'd0, 4'd0, 16'h5555);
    tick(2'b10, 1'b0);
    adv();
    idle();
    op(0, RD, 4'd0, 4'd9, 4'd10, 16'h0);
    push(1'b0, 16'h0000, 16'h5555);
    tick(2'b01, 1'b1);
    adv();
    idle();
    tick(2'b00, 1'b0);
    adv();

    // reset in the response cycle
    op(0, WR, 4'd2, 4'd0, 4'd0, 16'h1234);
    tick(2'b01, 1'b0);
    adv();
    op(0, RD, 4'd0, 4'd2, 4'd0, 16'h0);
    tick(2'b01, 1'b0);
    adv();
    idle();
    rst = 1'b0;
    tick(2'b00, 1'b0);
    chk("mid_rst_rf_en", 32'(rf_en), 32'd0);
    chk("mid_rst_rf_rst", 32'(rf_rst), 32'd0);
    adv();
    rst = 1'b1;
    @(negedge clk);
    chk("reclr_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("reclr_rf_rst", 32'(rf_rst), 32'd1);
    chk("reclr_ready", 32'(ready), 32'd0);
    adv();
    op(0, RD, 4'd0, 4'd2, 4'd0, 16'h0);
    push(1'b0, 16'h0000, 16'h0000);
    tick(2'b01, 1'b1);
    adv();
    idle();
    tick(2'b00, 1'b0);
    chk("exp_q_drained", 32'(exp_q.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
